// File: rtl/div_r4_pkg.sv
// Shared definitions for the radix-4 restoring divider: operand widths,
// iteration count and FSM state encoding.
package div_r4_pkg;

  localparam int unsigned DIVIDEND_W     = 32;
  localparam int unsigned DIVISOR_W      = 16;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned ITER_COUNT     = 8;
  localparam int unsigned DIVIDEND_BYTES = DIVIDEND_W / BYTE_W;
  localparam int unsigned DIVISOR_BYTES  = DIVISOR_W / BYTE_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_D,
    LOAD_V,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/div_r4_step.sv
// One radix-4 restoring division iteration: shift in two dividend bits and
// perform two chained trial subtractions, yielding two quotient bits.
module div_r4_step
  import div_r4_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem,
  input  logic [1:0]           bits,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_next,
  output logic [1:0]           q
);

  logic [DIVISOR_W:0]   trial_hi;
  logic [DIVISOR_W:0]   trial_lo;
  logic [DIVISOR_W-1:0] rem_mid;

  // The 17-bit trial value can exceed the divisor by less than one divisor,
  // so a successful subtraction always fits back into 16 bits.
  always_comb begin
    trial_hi = {rem, bits[1]};
    q[1]     = (trial_hi >= {1'b0, divisor});
    rem_mid  = q[1] ? (trial_hi[DIVISOR_W-1:0] - divisor) : trial_hi[DIVISOR_W-1:0];

    trial_lo = {rem_mid, bits[0]};
    q[0]     = (trial_lo >= {1'b0, divisor});
    rem_next = q[0] ? (trial_lo[DIVISOR_W-1:0] - divisor) : trial_lo[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/divide_r4.sv
// 32/16 unsigned radix-4 divider with byte-serial operand loading.
// Optional divide-by-zero / quotient-overflow rejection: DIV_R4_OVF_DETECT_EN.
module divide_r4
  import div_r4_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 getD,
  input  logic                 getV,
  input  logic [BYTE_W-1:0]    in,
  output logic [DIVISOR_W-1:0] quotient,
  output logic [DIVISOR_W-1:0] remainder,
  output logic                 ready,
  output logic                 err
);

  state_t                 state;
  state_t                 state_nxt;
  logic                   getd_q;
  logic                   getv_q;
  logic                   d_edge;
  logic                   v_edge;
  logic [1:0]             byte_cnt;
  logic [2:0]             iter;
  logic [DIVIDEND_W-1:0]  dividend;
  logic [DIVISOR_W-1:0]   divisor;
  logic [DIVISOR_W-1:0]   rem;
  logic [DIVISOR_W-1:0]   dlo;
  logic [DIVISOR_W-1:0]   rem_nxt;
  logic [1:0]             qbits;
  logic                   last_d;
  logic                   last_v;
  logic                   last_iter;
  logic                   reject;

  assign d_edge    = getD & ~getd_q;
  assign v_edge    = getV & ~getv_q;
  assign last_d    = d_edge && (byte_cnt == 2'(DIVIDEND_BYTES - 1));
  assign last_v    = v_edge && (byte_cnt == 2'(DIVISOR_BYTES - 1));
  assign last_iter = (iter == 3'(ITER_COUNT - 1));

`ifdef DIV_R4_OVF_DETECT_EN
  logic [DIVISOR_W-1:0] divisor_full;
  logic                 err_q;

  // The upper divisor byte is still on the bus during the final capture.
  assign divisor_full = {in, divisor[DIVISOR_W-1:BYTE_W]};
  assign reject       = (divisor_full == '0) ||
                        (dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor_full);
  assign err          = (state == DONE) && err_q;
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  div_r4_step u_step (
    .rem      (rem),
    .bits     (dlo[DIVISOR_W-1 -: 2]),
    .divisor  (divisor),
    .rem_next (rem_nxt),
    .q        (qbits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD_D;
      LOAD_D:  if (last_d) state_nxt = LOAD_V;
      LOAD_V:  if (last_v) state_nxt = reject ? DONE : CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    if (start) state_nxt = LOAD_D;
      default: state_nxt = IDLE;
    endcase
  end

  // rem holds the partial remainder; dlo shifts out dividend bits at the top
  // while quotient bits enter at the bottom, ending as the quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      getd_q   <= 1'b0;
      getv_q   <= 1'b0;
      byte_cnt <= '0;
      iter     <= '0;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      dlo      <= '0;
`ifdef DIV_R4_OVF_DETECT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      getd_q <= getD;
      getv_q <= getV;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            byte_cnt <= '0;
            iter     <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            dlo      <= '0;
`ifdef DIV_R4_OVF_DETECT_EN
            err_q    <= 1'b0;
`endif
          end
        end
        LOAD_D: begin
          if (d_edge) begin
            dividend <= {in, dividend[DIVIDEND_W-1:BYTE_W]};
            byte_cnt <= last_d ? '0 : byte_cnt + 2'd1;
          end
        end
        LOAD_V: begin
          if (v_edge) begin
            divisor  <= {in, divisor[DIVISOR_W-1:BYTE_W]};
            byte_cnt <= byte_cnt + 2'd1;
            if (last_v) begin
              iter <= '0;
              rem  <= dividend[DIVIDEND_W-1:DIVISOR_W];
              dlo  <= dividend[DIVISOR_W-1:0];
`ifdef DIV_R4_OVF_DETECT_EN
              if (reject) begin
                rem   <= dividend[DIVISOR_W-1:0];
                dlo   <= '1;
                err_q <= 1'b1;
              end
`endif
            end
          end
        end
        CALC: begin
          rem  <= rem_nxt;
          dlo  <= {dlo[DIVISOR_W-3:0], qbits};
          iter <= iter + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state == DONE);
  assign quotient  = (state == DONE) ? dlo : '0;
  assign remainder = (state == DONE) ? rem : '0;

endmodule

// File: tb/tb_divide_r4.sv
// Self-checking bench for divide_r4: directed and random divisions compared
// against plain integer division, plus reset, strobe and latency checks.
module tb_divide_r4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        getD;
  logic        getV;
  logic [7:0]  in;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        ready;
  logic        err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  divide_r4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .getD      (getD),
    .getV      (getV),
    .in        (in),
    .quotient  (quotient),
    .remainder (remainder),
    .ready     (ready),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, with rejection semantics when enabled.
  task automatic model(input logic [31:0] dvd, input logic [15:0] dvs,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic e, output int unsigned lat);
    logic [31:0] dvs32;
    dvs32 = {16'h0, dvs};
    e     = 1'b0;
    lat   = 9;
`ifdef DIV_R4_OVF_DETECT_EN
    if (dvs == 16'h0 || dvd[31:16] >= dvs) begin
      e   = 1'b1;
      lat = 1;
    end
`endif
    if (e) begin
      q = 16'hFFFF;
      r = dvd[15:0];
    end else begin
      q = 16'((dvd / dvs32) & 32'hFFFF);
      r = 16'(dvd % dvs32);
    end
  endtask

  // Runs one full transaction. rst_at>0 pulses reset in that CALC cycle instead.
  task automatic run_op(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                        input int unsigned hold_d, input bit v_noise, input bit s_noise,
                        input int unsigned rst_at);
    logic [15:0] eq, er;
    logic        ee;
    int unsigned elat;
    int unsigned lat;
    model(dvd, dvs, eq, er, ee, elat);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".ready_after_start"}, {31'h0, ready}, 32'h0);

    for (int i = 0; i < 4; i++) begin
      in   = dvd[8*i +: 8];
      getD = 1'b1;
      repeat (hold_d) @(negedge clk);
      getD = 1'b0;
      if (v_noise && i < 3) begin
        in   = 8'($urandom);
        getV = 1'b1;
      end
      @(negedge clk);
      getV = 1'b0;
    end

    in   = dvs[7:0];
    getV = 1'b1;
    @(negedge clk);
    getV = 1'b0;
    @(negedge clk);
    in   = dvs[15:8];
    getV = 1'b1;
    @(negedge clk);
    getV = 1'b0;
    in   = 8'($urandom);
    lat  = 1;

    while (ready !== 1'b1 && lat < 30) begin
      if (lat == 4) begin
        check({tag, ".calc_ready_low"}, {31'h0, ready}, 32'h0);
        check({tag, ".calc_quot_zero"}, {16'h0, quotient}, 32'h0);
        if (rst_at == 4) begin
          rst_n = 1'b0;
          #1;
          check({tag, ".rst_outputs"}, {quotient, remainder}, 32'h0);
          check({tag, ".rst_flags"}, {30'h0, ready, err}, 32'h0);
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          check({tag, ".rst_idle"}, {31'h0, ready}, 32'h0);
          return;
        end
      end
      if (s_noise && lat == 3) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat++;
    end

    check({tag, ".latency"}, lat, elat);
    check({tag, ".quotient"}, {16'h0, quotient}, {16'h0, eq});
    check({tag, ".remainder"}, {16'h0, remainder}, {16'h0, er});
    check({tag, ".err"}, {31'h0, err}, {31'h0, ee});
    repeat (3) @(negedge clk);
    check({tag, ".hold"}, {15'h0, ready, quotient}, {15'h0, 1'b1, eq});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    getD  = 1'b0;
    getV  = 1'b0;
    in    = 8'h0;
    repeat (2) @(negedge clk);
    check("reset.outputs", {quotient, remainder}, 32'h0);
    check("reset.flags", {30'h0, ready, err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.ready", {31'h0, ready}, 32'h0);

    run_op("d100000_300", 32'h000186A0, 16'h012C, 1, 1'b0, 1'b0, 0);
    check("d100000_300.q_const", {16'h0, quotient}, 32'h0000014D);
    check("d100000_300.r_const", {16'h0, remainder}, 32'h00000064);
    run_op("max", 32'hFFFE0001, 16'hFFFF, 1, 1'b0, 1'b0, 0);
    check("max.q_const", {16'h0, quotient}, 32'h0000FFFF);
    run_op("held_getd", 32'h00010000, 16'h0003, 3, 1'b0, 1'b0, 0);
    check("held_getd.q_const", {16'h0, quotient}, 32'h00005555);
    check("held_getd.r_const", {16'h0, remainder}, 32'h00000001);

`ifdef DIV_R4_OVF_DETECT_EN
    run_op("div_zero", 32'h00001234, 16'h0000, 1, 1'b0, 1'b0, 0);
    check("div_zero.err_const", {31'h0, err}, 32'h1);
    run_op("ovf", 32'h00030000, 16'h0003, 1, 1'b0, 1'b0, 0);
    check("ovf.q_const", {16'h0, quotient}, 32'h0000FFFF);
`endif

    run_op("rst_calc", 32'h000186A0, 16'h012C, 1, 1'b0, 1'b0, 4);
    run_op("after_rst", 32'h000186A0, 16'h012C, 1, 1'b0, 1'b0, 0);
    check("after_rst.q_const", {16'h0, quotient}, 32'h0000014D);
    run_op("noise", 32'h000186A0, 16'h012C, 2, 1'b1, 1'b1, 0);

    for (int n = 0; n < 8; n++) begin
      logic [15:0] dvs;
      logic [31:0] dvd;
      dvs = 16'($urandom_range(1, 65535));
      dvd = {16'($urandom % {16'h0, dvs}), 16'($urandom)};
      run_op($sformatf("rand%0d", n), dvd, dvs, $urandom_range(1, 3),
             1'($urandom), 1'($urandom), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divide_r4.md
DIVIDE_R4 -- requirements
Module: divide_r4

Interface
REQ-001 SHALL provide port clk  input  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL provide port start  input  1  begins a new division when sampled high in IDLE or DONE.
REQ-004 SHALL provide port getD  input  1  dividend byte strobe.
REQ-005 SHALL provide port getV  input  1  divisor byte strobe.
REQ-006 SHALL provide port in  input  8  byte bus for dividend and divisor bytes.
REQ-007 SHALL provide port quotient  output  16  unsigned quotient.
REQ-008 SHALL provide port remainder  output  16  unsigned remainder.
REQ-009 SHALL provide port ready  output  1  high while quotient and remainder are valid.
REQ-010 SHALL provide port err  output  1  high with ready when the division was rejected (divide-by-zero or quotient overflow).

Function
REQ-011 SHALL divide an unsigned 32-bit dividend by an unsigned 16-bit divisor, inverting the team's 16x16 radix-4 multiplier.
REQ-012 SHALL implement states IDLE, LOAD_D, LOAD_V, CALC, DONE.
REQ-013 SHALL go IDLE->LOAD_D and DONE->LOAD_D when start is sampled high; ready and err drop in that same cycle.
REQ-014 SHALL capture one byte per strobe rising edge (strobe low in previous cycle, high now); a held strobe captures only once.
REQ-015 SHALL load four dividend bytes in LOAD_D, least significant first, then move to LOAD_V.
REQ-016 SHALL load two divisor bytes in LOAD_V, least significant first, then move to CALC on the cycle after the second capture.
REQ-017 SHALL ignore getV in LOAD_D, getD in LOAD_V, both strobes in other states, and start outside IDLE/DONE.
REQ-018 SHALL produce two quotient bits per CALC cycle using a 17-bit partial remainder and two chained restoring trial subtractions.
REQ-019 SHALL spend exactly 8 CALC cycles, counted by a 3-bit iteration counter; DONE entered on the cycle after the 8th.
REQ-020 SHALL hold quotient, remainder, ready=1 in DONE until start or reset.
REQ-021 SHALL keep quotient and remainder at 0 and ready low in IDLE, LOAD_D, LOAD_V, CALC.

Reset
REQ-022 SHALL, on rst_n low at any time including mid-load or mid-CALC, enter IDLE and clear all registers, byte and iteration counters; outputs quotient=0, remainder=0, ready=0, err=0.
REQ-023 SHALL leave reset on the first rising clk edge after rst_n deasserts, with no partial operand retained.

Configuration
REQ-024 SHALL use macro DIV_R4_OVF_DETECT_EN.
REQ-025 SHALL, when DIV_R4_OVF_DETECT_EN is defined, check on LOAD_V exit whether divisor==0 or dividend[31:16]>=divisor; if so skip CALC, enter DONE next cycle with err=1, quotient=16'hFFFF, remainder=dividend[15:0].
REQ-026 SHALL, when DIV_R4_OVF_DETECT_EN is undefined, tie err to 0, always run 8 CALC cycles, and leave results for rejected-class inputs unspecified.

Structure
REQ-027 SHALL place the state encoding, iteration count 8, and operand widths 32/16/8 in shared package div_r4_pkg.
REQ-028 SHALL factor one radix-4 iteration (shift, two trial subtractions, two quotient bits) into combinational sub-module div_r4_step.

Verification
REQ-029 SHALL cover: dividend bytes A0 86 01 00, divisor 2C 01 -> after 8 CALC cycles quotient=16'h014D, remainder=16'h0064, err=0.
REQ-030 SHALL cover: dividend 32'hFFFE0001, divisor 16'hFFFF -> quotient=16'hFFFF, remainder=16'h0000.
REQ-031 SHALL cover: dividend 32'h00010000, divisor 16'h0003 -> quotient=16'h5555, remainder=16'h0001; getD held high 3 cycles per byte captures once.
REQ-032 SHALL cover (macro on): divisor 0, then dividend 32'h00030000 / divisor 3 -> each ready one cycle after LOAD_V exit, err=1, quotient=16'hFFFF.
REQ-033 SHALL cover: rst_n pulsed low in CALC cycle 4 -> outputs 0 immediately, IDLE; next full operation 100000/300 gives 16'h014D r 16'h0064.
REQ-034 SHALL cover: getV pulses during LOAD_D and start pulses during CALC are ignored; results unchanged.
